writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock is clk, reset is reset_n.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, the load-result queue depth; it SHALL be a power of 2 and at least 2.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port reset_n  input  1  asynchronous active-low reset.
REQ-005 Port alu_valid_i  input  1  ALU result available this cycle; never stalled.
REQ-006 Port alu_reg_i  input  7  ALU destination as {strand[1:0], reg[4:0]}.
REQ-007 Port alu_value_i  input  32  ALU result.
REQ-008 Port load_valid_i  input  1  load result offered.
REQ-009 Port load_reg_i  input  7  load destination, same encoding.
REQ-010 Port load_value_i  input  32  load data.
REQ-011 Port load_ready_o  output  1  load result accepted when load_valid_i and load_ready_o are both high at the clock edge.
REQ-012 Port write_enable_o  output  1  registered register-file write strobe.
REQ-013 Port write_reg_o  output  7  registered write index.
REQ-014 Port write_value_o  output  32  registered write data.
REQ-015 Port check_reg_i  input  7  hazard lookup index.
REQ-016 Port check_hit_o  output  1  combinational; high if any queued FIFO entry targets check_reg_i.

Function
REQ-017 Outputs write_* SHALL be registered, with one write per cycle maximum.
REQ-018 Per-cycle output selection priority SHALL be: ALU if alu_valid_i; else FIFO head if FIFO not empty; else bypass load (see Configuration); else write_enable_o=0.
REQ-019 When write_enable_o is 0, write_reg_o and write_value_o SHALL hold their previous values.
REQ-020 An accepted load that does not reach the output register that cycle SHALL be pushed to the FIFO tail.
REQ-021 The FIFO SHALL pop in order only when selected by REQ-018, so loads retire in acceptance order.
REQ-022 load_ready_o SHALL equal "FIFO count < FIFO_DEPTH", derived from registered count only; a push is refused when full, even if a pop occurs the same cycle.
REQ-023 Push and pop in the same cycle SHALL leave the count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 The count SHALL be log2(FIFO_DEPTH)+1 bits wide and SHALL never exceed FIFO_DEPTH or underflow.
REQ-025 check_hit_o SHALL compare only valid entries (head..tail-1); the output register is not included.
REQ-026 An ALU write and a queued load to the same register SHALL both be written, ALU first; ordering is the issue logic's responsibility.

Reset
REQ-027 Asserting reset_n low SHALL immediately clear write_enable_o, write_reg_o, write_value_o, FIFO count and pointers; load_ready_o SHALL then be 1.
REQ-028 Entries queued at reset SHALL be discarded; the FIFO data array need not be reset.
REQ-029 Release of reset_n SHALL be synchronous to clk; first accept is possible on the first edge after release.

Configuration
REQ-030 With WB_BYPASS_EN defined, a load accepted while alu_valid_i=0 and FIFO empty SHALL go directly to the output register, giving 1-cycle latency, and SHALL not be pushed.
REQ-031 Without WB_BYPASS_EN, every accepted load SHALL be pushed, and reach the output no earlier than 2 cycles after acceptance.

Verification
REQ-032 Reset: hold reset_n=0 mid-stream with 3 entries queued -> write_enable_o=0, load_ready_o=1, check_hit_o=0 for any check_reg_i.
REQ-033 Priority: alu_valid_i with reg 0x05, value 0xAAAA0001, and load reg 0x06, value 0xBBBB0002 in same cycle, FIFO empty -> cycle+1 writes 0x05/0xAAAA0001, cycle+2 writes 0x06/0xBBBB0002.
REQ-034 Full: ALU valid every cycle, 5 loads offered -> load_ready_o drops after 4 accepts, 5th held; after ALU stops, 4 writes in acceptance order, then 5th accepted.
REQ-035 Hazard: queue load to reg 0x23 -> check_reg_i=0x23 gives check_hit_o=1, 0x24 gives 0; after the entry drains, 0x23 gives 0.
REQ-036 Bypass: idle, single load reg 0x7F, value 0x12345678 -> write at cycle+1 with WB_BYPASS_EN, at cycle+2 without.
REQ-037 Wrap: 12 load pushes/pops with intermittent ALU traffic -> all 12 written once, in order, with no loss or duplication.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: ALU results win, queued loads drain in order; WB_BYPASS_EN lets an idle-cycle load skip the queue.
// Latency: ALU 1 cycle, load 2+ cycles (1 with bypass); loads backpressured via load_ready_o when the queue is full.
module writeback_arbiter #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        alu_valid_i,
   input  logic [6:0]  alu_reg_i,
   input  logic [31:0] alu_value_i,
   input  logic        load_valid_i,
   input  logic [6:0]  load_reg_i,
   input  logic [31:0] load_value_i,
   output logic        load_ready_o,
   output logic        write_enable_o,
   output logic [6:0]  write_reg_o,
   output logic [31:0] write_value_o,
   input  logic [6:0]  check_reg_i,
   output logic        check_hit_o
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
`ifdef WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and at least 2");
   end

   typedef struct packed {
      logic [6:0]  dst;
      logic [31:0] value;
   } entry_t;

   entry_t        mem_q [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          write_enable_q, write_enable_d;
   logic [6:0]    write_reg_q, write_reg_d;
   logic [31:0]   write_value_q, write_value_d;
   logic          fifo_empty, load_accept, push, pop, bypass;
   entry_t        head;
   logic [FIFO_DEPTH-1:0] entry_hit;

   assign fifo_empty   = (count_q == '0);
   assign load_ready_o = (count_q < CW'(FIFO_DEPTH));
   assign load_accept  = load_valid_i & load_ready_o;
   assign head         = mem_q[rd_ptr_q];

   always_comb begin
      write_enable_d = 1'b0;
      write_reg_d    = write_reg_q;
      write_value_d  = write_value_q;
      pop            = 1'b0;
      bypass         = 1'b0;
      if (alu_valid_i) begin
         write_enable_d = 1'b1;
         write_reg_d    = alu_reg_i;
         write_value_d  = alu_value_i;
      end else if (!fifo_empty) begin
         write_enable_d = 1'b1;
         write_reg_d    = head.dst;
         write_value_d  = head.value;
         pop            = 1'b1;
      end else if (BYPASS && load_accept) begin
         write_enable_d = 1'b1;
         write_reg_d    = load_reg_i;
         write_value_d  = load_value_i;
         bypass         = 1'b1;
      end
      push = load_accept & ~bypass;
   end

   // Power-of-2 depth makes natural pointer overflow the modulo wrap.
   always_comb begin
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         count_q        <= '0;
         write_enable_q <= 1'b0;
         write_reg_q    <= '0;
         write_value_q  <= '0;
      end else begin
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         count_q        <= count_d;
         write_enable_q <= write_enable_d;
         write_reg_q    <= write_reg_d;
         write_value_q  <= write_value_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{dst: load_reg_i, value: load_value_i};
      end
   end

   // An entry is live when its distance from the head is below the count.
   for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_hit
      logic [AW-1:0] offset;
      assign offset       = AW'(i) - rd_ptr_q;
      assign entry_hit[i] = ({1'b0, offset} < count_q) && (mem_q[i].dst == check_reg_i);
   end

   assign check_hit_o    = |entry_hit;
   assign write_enable_o = write_enable_q;
   assign write_reg_o    = write_reg_q;
   assign write_value_o  = write_value_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: fixed vector table, directed corner sequences and a queue-based random reference.
module tb_writeback_arbiter;
   localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        alu_valid_i;
   logic [6:0]  alu_reg_i;
   logic [31:0] alu_value_i;
   logic        load_valid_i;
   logic [6:0]  load_reg_i;
   logic [31:0] load_value_i;
   logic        load_ready_o;
   logic        write_enable_o;
   logic [6:0]  write_reg_o;
   logic [31:0] write_value_o;
   logic [6:0]  check_reg_i;
   logic        check_hit_o;

   always #5 clk = ~clk;

   writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .alu_valid_i    (alu_valid_i),
      .alu_reg_i      (alu_reg_i),
      .alu_value_i    (alu_value_i),
      .load_valid_i   (load_valid_i),
      .load_reg_i     (load_reg_i),
      .load_value_i   (load_value_i),
      .load_ready_o   (load_ready_o),
      .write_enable_o (write_enable_o),
      .write_reg_o    (write_reg_o),
      .write_value_o  (write_value_o),
      .check_reg_i    (check_reg_i),
      .check_hit_o    (check_hit_o)
   );

   typedef struct {
      logic [6:0]  r;
      logic [31:0] v;
   } ent_t;

   typedef struct {
      logic        av;
      logic [6:0]  ar;
      logic [31:0] ad;
      logic        lv;
      logic [6:0]  lr;
      logic [31:0] ld;
      logic [6:0]  cr;
      logic        e_rdy;
      logic        e_hit;
      logic        e_we;
      logic [6:0]  e_reg;
      logic [31:0] e_val;
   } vec_t;

   ent_t        mq[$];
   ent_t        got[$];
   vec_t        tbl[11];
   logic        m_we;
   logic [6:0]  m_reg;
   logic [31:0] m_val;
   bit          last_acc;
   int          n_checks = 0;
   int          n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_we  = 1'b0;
      m_reg = '0;
      m_val = '0;
   endtask

   task automatic drive(input logic av, input logic [6:0] ar, input logic [31:0] ad,
                        input logic lv, input logic [6:0] lr, input logic [31:0] ld,
                        input logic [6:0] cr);
      alu_valid_i  = av;
      alu_reg_i    = ar;
      alu_value_i  = ad;
      load_valid_i = lv;
      load_reg_i   = lr;
      load_value_i = ld;
      check_reg_i  = cr;
   endtask

   // One clock: check combinational outputs against the queue model, advance the model, check the registered write.
   task automatic tick(input string tag);
      bit   rdy, hit, byp;
      ent_t e;
      #1;
      rdy = (mq.size() < DEPTH);
      hit = 1'b0;
      foreach (mq[i]) if (mq[i].r == check_reg_i) hit = 1'b1;
      check({tag, " ready"}, load_ready_o, rdy);
      check({tag, " hit"}, check_hit_o, hit);
      last_acc = load_valid_i && rdy;
      byp = 1'b0;
      if (alu_valid_i) begin
         m_we = 1'b1; m_reg = alu_reg_i; m_val = alu_value_i;
      end else if (mq.size() > 0) begin
         e = mq.pop_front();
         m_we = 1'b1; m_reg = e.r; m_val = e.v;
      end else if (BYP && last_acc) begin
         m_we = 1'b1; m_reg = load_reg_i; m_val = load_value_i; byp = 1'b1;
      end else begin
         m_we = 1'b0;
      end
      if (last_acc && !byp) begin
         e.r = load_reg_i; e.v = load_value_i;
         mq.push_back(e);
      end
      @(posedge clk);
      #1;
      check({tag, " we"}, write_enable_o, m_we);
      check({tag, " reg"}, write_reg_o, m_reg);
      check({tag, " val"}, write_value_o, m_val);
      if (write_enable_o === 1'b1) begin
         e.r = write_reg_o; e.v = write_value_o;
         got.push_back(e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int k, sent, nload;
      ent_t loads[$];

      // Priority, bypass latency and hazard lookup, expected values written out by hand.
      tbl[0]  = '{1'b1, 7'h05, 32'hAAAA0001, 1'b1, 7'h06, 32'hBBBB0002, 7'h06, 1'b1, 1'b0, 1'b1, 7'h05, 32'hAAAA0001};
      tbl[1]  = '{1'b0, 7'h00, 32'h0, 1'b0, 7'h00, 32'h0, 7'h06, 1'b1, 1'b1, 1'b1, 7'h06, 32'hBBBB0002};
      tbl[2]  = '{1'b0, 7'h00, 32'h0, 1'b0, 7'h00, 32'h0, 7'h06, 1'b1, 1'b0, 1'b0, 7'h06, 32'hBBBB0002};
`ifdef WB_BYPASS_EN
      tbl[3]  = '{1'b0, 7'h00, 32'h0, 1'b1, 7'h7F, 32'h12345678, 7'h7F, 1'b1, 1'b0, 1'b1, 7'h7F, 32'h12345678};
      tbl[4]  = '{1'b0, 7'h00, 32'h0, 1'b0, 7'h00, 32'h0, 7'h7F, 1'b1, 1'b0, 1'b0, 7'h7F, 32'h12345678};
`else
      tbl[3]  = '{1'b0, 7'h00, 32'h0, 1'b1, 7'h7F, 32'h12345678, 7'h7F, 1'b1, 1'b0, 1'b0, 7'h06, 32'hBBBB0002};
      tbl[4]  = '{1'b0, 7'h00, 32'h0, 1'b0, 7'h00, 32'h0, 7'h7F, 1'b1, 1'b1, 1'b1, 7'h7F, 32'h12345678};
`endif
      tbl[5]  = '{1'b0, 7'h00, 32'h0, 1'b0, 7'h00, 32'h0, 7'h7F, 1'b1, 1'b0, 1'b0, 7'h7F, 32'h12345678};
      tbl[6]  = '{1'b1, 7'h01, 32'h00000011, 1'b1, 7'h23, 32'hCAFE0023, 7'h23, 1'b1, 1'b0, 1'b1, 7'h01, 32'h00000011};
      tbl[7]  = '{1'b1, 7'h02, 32'h00000022, 1'b0, 7'h00, 32'h0, 7'h23, 1'b1, 1'b1, 1'b1, 7'h02, 32'h00000022};
      tbl[8]  = '{1'b1, 7'h03, 32'h00000033, 1'b0, 7'h00, 32'h0, 7'h24, 1'b1, 1'b0, 1'b1, 7'h03, 32'h00000033};
      tbl[9]  = '{1'b0, 7'h00, 32'h0, 1'b0, 7'h00, 32'h0, 7'h23, 1'b1, 1'b1, 1'b1, 7'h23, 32'hCAFE0023};
      tbl[10] = '{1'b0, 7'h00, 32'h0, 1'b0, 7'h00, 32'h0, 7'h23, 1'b1, 1'b0, 1'b0, 7'h23, 32'hCAFE0023};

      reset_n = 1'b0;
      drive(1'b0, 7'h0, 32'h0, 1'b0, 7'h0, 32'h0, 7'h0);
      model_reset();
      #2;
      check("reset we", write_enable_o, 1'b0);
      check("reset reg", write_reg_o, 7'h0);
      check("reset val", write_value_o, 32'h0);
      check("reset ready", load_ready_o, 1'b1);
      check("reset hit", check_hit_o, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].lv, tbl[i].lr, tbl[i].ld, tbl[i].cr);
         #1;
         check($sformatf("vec%0d ready", i), load_ready_o, tbl[i].e_rdy);
         check($sformatf("vec%0d hit", i), check_hit_o, tbl[i].e_hit);
         tick($sformatf("vec%0d model", i));
         check($sformatf("vec%0d we", i), write_enable_o, tbl[i].e_we);
         check($sformatf("vec%0d reg", i), write_reg_o, tbl[i].e_reg);
         check($sformatf("vec%0d val", i), write_value_o, tbl[i].e_val);
      end

      // Full queue under continuous ALU traffic, then drain.
      got.delete();
      k = 0;
      for (int c = 0; c < 8; c++) begin
         drive(1'b1, 7'(7'h10 + c), 32'hA1000000 + c, 1'b1, 7'(7'h40 + k), 32'hF00D0000 + k, 7'h40);
         tick("full");
         if (last_acc) k++;
      end
      check("full accepts", k, 4);
      check("full ready low", load_ready_o, 1'b0);
      for (int c = 0; c < 20 && !(k == 5 && mq.size() == 0); c++) begin
         drive(1'b0, 7'h0, 32'h0, (k < 5), 7'(7'h40 + k), 32'hF00D0000 + k, 7'h44);
         tick("drain");
         if (last_acc) k++;
      end
      check("full fifth accepted", k, 5);
      nload = 0;
      foreach (got[i]) begin
         if (got[i].r >= 7'h40 && got[i].r <= 7'h44) begin
            check($sformatf("full order %0d", nload), got[i].v, 32'hF00D0000 + nload);
            nload++;
         end
      end
      check("full load writes", nload, 5);

      // Pointer wrap: 12 loads interleaved with random ALU writes.
      got.delete();
      sent = 0;
      for (int c = 0; c < 300 && !(sent == 12 && mq.size() == 0); c++) begin
         drive(($urandom_range(0, 2) == 0), 7'($urandom_range(0, 15)), 32'hA1A10000 | $urandom_range(0, 255),
               (sent < 12) && ($urandom_range(0, 3) != 0), 7'(7'h30 + sent), 32'h1EAD0000 + sent,
               7'($urandom_range(7'h30, 7'h3F)));
         tick("wrap");
         if (last_acc) sent++;
      end
      loads.delete();
      foreach (got[i]) if (got[i].v[31:16] == 16'h1EAD) loads.push_back(got[i]);
      check("wrap count", loads.size(), 12);
      foreach (loads[i]) check($sformatf("wrap order %0d", i), loads[i].v, 32'h1EAD0000 + i);

      // Random traffic against the reference model.
      for (int c = 0; c < 400; c++) begin
         drive(($urandom_range(0, 9) < 6), 7'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 3) != 0), 7'($urandom_range(0, 7)), $urandom,
               7'($urandom_range(0, 7)));
         tick("rand");
      end

      // Reset with three loads queued.
      for (int c = 0; c < 10 && mq.size() > 0; c++) begin
         drive(1'b0, 7'h0, 32'h0, 1'b0, 7'h0, 32'h0, 7'h0);
         tick("pre-reset drain");
      end
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 7'(7'h08 + c), 32'hC0DE0000 + c, 1'b1, 7'(7'h61 + c), 32'h61610000 + c, 7'h61);
         tick("pre-reset fill");
      end
      #1;
      check("queued hit before reset", check_hit_o, 1'b1);
      reset_n = 1'b0;
      model_reset();
      #1;
      check("midreset we", write_enable_o, 1'b0);
      check("midreset reg", write_reg_o, 7'h0);
      check("midreset val", write_value_o, 32'h0);
      check("midreset ready", load_ready_o, 1'b1);
      for (int c = 0; c < 4; c++) begin
         check_reg_i = (c < 3) ? 7'(7'h61 + c) : 7'h00;
         #1;
         check($sformatf("midreset hit %0d", c), check_hit_o, 1'b0);
      end
      drive(1'b0, 7'h0, 32'h0, 1'b0, 7'h0, 32'h0, 7'h0);
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b0, 7'h0, 32'h0, 1'b1, 7'h11, 32'h00005A5A, 7'h11);
      tick("post-reset load");
      check("post-reset accepted", last_acc, 1'b1);
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 7'h0, 32'h0, 1'b0, 7'h0, 32'h0, 7'h11);
         tick("post-reset idle");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
